// File: rtl/oclib_uart_responder.sv
// oclib_uart_responder: ASCII command responder over a UART byte stream, 16x32-bit register bank
// Ports: clock/reset (async, active-high); rxData/rxValid/rxReady command bytes in;
// txData/txValid/txReady response bytes out; regs flat register file; error malformed/timeout pulse.
module oclib_uart_responder #(
  parameter logic [31:0] ResetValue    = 32'h0,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   rxData,
  input  logic         rxValid,
  output logic         rxReady,
  output logic [7:0]   txData,
  output logic         txValid,
  input  logic         txReady,
  output logic [511:0] regs,
  output logic         error
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2,
                         S_EOL = 3'd3, S_FLUSH = 3'd4, S_RESP = 3'd5;
  localparam logic [1:0] K_RD = 2'd0, K_OK = 2'd1, K_ERR = 2'd2;
  localparam logic [7:0] C_LF = 8'h0a, C_CR = 8'h0d;
  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [3:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0][31:0] regs_q, regs_d;
  logic              rx_ready_q;
  logic              err_q, err_d;
  logic [31:0]       resp_q, resp_d;
  logic [1:0]        kind_q, kind_d;
  logic [3:0]        idx_q, idx_d;
  logic [31:0]       to_q, to_d;
  logic              is_hex, rx_acc, lf, cr, last, bad;
  logic [3:0]        nib;
  logic [7:0]        digit;
  assign rx_acc  = rxValid && rx_ready_q;
  assign lf      = rxData == C_LF;
  assign cr      = rxData == C_CR;
  assign rxReady = rx_ready_q;
  assign txValid = state_q == S_RESP;
  assign regs    = regs_q;
  assign error   = err_q;
  // read responses shift resp_q left per byte, so the current digit is always the top nibble
  assign last    = idx_q == ((kind_q == K_RD) ? 4'd8 : 4'd1);
  assign digit   = (resp_q[31:28] < 4'd10) ? {4'h3, resp_q[31:28]} : 8'h37 + {4'h0, resp_q[31:28]};
  assign txData  = !txValid ? 8'h00 : last ? C_LF : (kind_q == K_RD) ? digit :
                   (kind_q == K_OK) ? 8'h6b : 8'h3f;
  always_comb begin
    is_hex = 1'b1;
    nib    = rxData[3:0];
    if (rxData >= 8'h30 && rxData <= 8'h39) nib = rxData[3:0];
    else if ((rxData >= 8'h41 && rxData <= 8'h46) || (rxData >= 8'h61 && rxData <= 8'h66)) nib = rxData[3:0] + 4'd9;
    else is_hex = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    err_d   = 1'b0;
    resp_d  = resp_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    to_d    = 32'd0;
    bad     = 1'b0;
    if (state_q == S_RESP) begin
      if (txReady) begin
        state_d = last ? S_IDLE : S_RESP;
        idx_d   = idx_q + 4'd1;
        resp_d  = resp_q << 4;
      end
    end else if (rx_acc && !cr) begin
      case (state_q)
        S_IDLE: begin
          if (rxData == 8'h77 || rxData == 8'h72) begin
            state_d = S_ADDR;
            wr_d    = rxData == 8'h77;
          end else bad = !lf;
        end
        S_ADDR: begin
          addr_d  = nib;
          cnt_d   = 3'd0;
          state_d = wr_q ? S_DATA : S_EOL;
          bad     = !is_hex;
        end
        S_DATA: begin
          data_d  = {data_q[27:0], nib};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? S_EOL : S_DATA;
          bad     = !is_hex;
        end
        S_EOL: begin
          state_d = S_RESP;
          idx_d   = 4'd0;
          kind_d  = wr_q ? K_OK : K_RD;
          resp_d  = regs_q[addr_q];
          if (wr_q) regs_d[addr_q] = data_q;
          bad     = !lf;
        end
        S_FLUSH: begin
          state_d = lf ? S_RESP : S_FLUSH;
          kind_d  = K_ERR;
          idx_d   = 4'd0;
        end
        default: state_d = S_IDLE;
      endcase
      // a bad '\n' is itself the end of the flushed line, so answer straight away
      if (bad) begin
        regs_d  = regs_q;
        err_d   = 1'b1;
        state_d = lf ? S_RESP : S_FLUSH;
        kind_d  = K_ERR;
        idx_d   = 4'd0;
      end
    end
    if (TimeoutCycles != 0 && !rx_acc && state_q inside {S_ADDR, S_DATA, S_EOL, S_FLUSH}) begin
      to_d = to_q + 32'd1;
      if (to_d == TimeoutCycles) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        to_d    = 32'd0;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= 4'd0;
      data_q     <= 32'd0;
      cnt_q      <= 3'd0;
      regs_q     <= {16{ResetValue}};
      rx_ready_q <= 1'b0;
      err_q      <= 1'b0;
      resp_q     <= 32'd0;
      kind_q     <= K_RD;
      idx_q      <= 4'd0;
      to_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      regs_q     <= regs_d;
      rx_ready_q <= state_d != S_RESP;
      err_q      <= err_d;
      resp_q     <= resp_d;
      kind_q     <= kind_d;
      idx_q      <= idx_d;
      to_q       <= to_d;
    end
  end
endmodule

// File: tb/tb_oclib_uart_responder.sv
// tb_oclib_uart_responder: scoreboard bench with a line-level reference model
module tb_oclib_uart_responder;
  localparam logic [31:0] RV = 32'hC0FFEE01;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rxData = 8'h00;
  logic         rxValid = 1'b0;
  logic         rxReady;
  logic [7:0]   txData;
  logic         txValid;
  logic         txReady = 1'b0;
  logic [511:0] regs;
  logic         error;
  int checks = 0, errors = 0;
  int exp_err = 0, err_seen = 0, popped = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model[16];
  bit bp_hold = 1'b0;
  always #5 clock = ~clock;
  oclib_uart_responder #(.ResetValue(RV), .TimeoutCycles(50)) dut (
    .clock(clock), .reset(reset), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .txData(txData), .txValid(txValid), .txReady(txReady), .regs(regs), .error(error)
  );
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [511:0] packed_model();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = model[i];
    return p;
  endfunction
  function automatic int hv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c - 8'h30);
    if (c >= "a" && c <= "f") return int'(c - 8'h61) + 10;
    if (c >= "A" && c <= "F") return int'(c - 8'h41) + 10;
    return -1;
  endfunction
  function automatic logic [7:0] hexc(input int n, input bit upper);
    return (n < 10) ? 8'(8'h30 + n) : 8'((upper ? 8'h41 : 8'h61) + n - 10);
  endfunction
  // evaluate one full line (without its '\n') as the spec grammar describes
  task automatic model_line(input string s);
    logic [7:0] c[$];
    logic [31:0] v;
    bit ok;
    for (int i = 0; i < s.len(); i++) if (s[i] != 8'h0d) c.push_back(s[i]);
    if (c.size() == 0) return;
    ok = c.size() >= 2 && hv(c[1]) >= 0;
    if (c[0] == "w" && c.size() == 10 && ok) begin
      v = 0;
      for (int i = 2; i < 10; i++) begin
        if (hv(c[i]) < 0) ok = 0;
        v = {v[27:0], 4'(hv(c[i]))};
      end
    end
    if (ok && c[0] == "w" && c.size() == 10) begin
      model[hv(c[1])] = v;
      exp_q.push_back("k");
      exp_q.push_back(8'h0a);
    end else if (ok && c[0] == "r" && c.size() == 2) begin
      v = model[hv(c[1])];
      for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(int'(v[4*i +: 4]), 1));
      exp_q.push_back(8'h0a);
    end else begin
      exp_q.push_back("?");
      exp_q.push_back(8'h0a);
      exp_err++;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n = 0;
    rxData  = b;
    rxValid = 1'b1;
    do begin
      @(negedge clock);
      ok = rxReady;
      @(posedge clock);
      n++;
    end while (!ok && n < 2000);
    #1;
    rxValid = 1'b0;
    if (!ok) begin
      $display("FAIL rx_handshake_timeout got 0 want 1");
      $fatal(1, "rx stalled");
    end
  endtask
  task automatic send_cmd(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    model_line(s.substr(0, s.len() - 2));
    chk("regs_after_lf", regs, packed_model());
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || txValid) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drained", 512'(exp_q.size()), 512'd0);
    chk("error_count", 512'(err_seen), 512'(exp_err));
  endtask
  initial forever begin
    @(posedge clock);
    #1;
    txReady = bp_hold ? 1'b0 : ($urandom_range(3) != 0);
  end
  initial begin : monitor
    bit stall = 0;
    logic [7:0] stall_data = 0;
    forever begin
      @(negedge clock);
      if (error) err_seen++;
      if (txValid) chk("rxready_low_in_resp", 512'(rxReady), 512'd0);
      if (stall && txValid) chk("txdata_stable", 512'(txData), 512'(stall_data));
      stall = txValid && !txReady;
      stall_data = txData;
      if (txValid && txReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx got %0h want none", txData);
        end else chk("tx_byte", 512'(txData), 512'(exp_q.pop_front()));
        popped++;
      end
    end
  end
  initial begin
    string s;
    int n, p0;
    for (int i = 0; i < 16; i++) model[i] = RV;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rxready", 512'(rxReady), 512'd0);
    chk("reset_txvalid", 512'(txValid), 512'd0);
    chk("reset_txdata", 512'(txData), 512'd0);
    chk("reset_error", 512'(error), 512'd0);
    chk("reset_regs", regs, packed_model());
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rxready_after_reset", 512'(rxReady), 512'd1);
    send_cmd("w3DEADBEEF\n");
    chk("w3_slice", 512'(regs[127:96]), 512'(32'hDEADBEEF));
    wait_idle();
    send_cmd("r3\n");
    wait_idle();
    send_cmd("wa0000abcd\r\n");
    send_cmd("rA\n");
    wait_idle();
    send_cmd("x\n");
    wait_idle();
    send_cmd("r\n");
    wait_idle();
    send_cmd("w1123\n");
    wait_idle();
    send_cmd("r1Z\n");
    wait_idle();
    bp_hold = 1'b1;
    send_cmd("r3\n");
    repeat (20) begin
      @(negedge clock);
      chk("bp_txvalid", 512'(txValid), 512'd1);
      chk("bp_txdata", 512'(txData), 512'("D"));
      chk("bp_rxready", 512'(rxReady), 512'd0);
    end
    bp_hold = 1'b0;
    wait_idle();
    foreach (s_w5[i]) send_byte(s_w5[i]);
    n = 0;
    exp_err++;
    do begin
      @(negedge clock);
      n++;
    end while (!error && n < 100);
    chk("timeout_cycle_window", 512'(n >= 48 && n <= 52), 512'd1);
    repeat (5) @(negedge clock);
    chk("timeout_no_resp", 512'(txValid), 512'd0);
    @(posedge clock);
    #1;
    send_cmd("r5\n");
    wait_idle();
    p0 = popped;
    send_cmd("r3\n");
    n = 0;
    while (popped < p0 + 3 && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_txvalid", 512'(txValid), 512'd0);
    chk("midreset_rxready", 512'(rxReady), 512'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) model[i] = RV;
    chk("midreset_regs", regs, packed_model());
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    send_cmd("r0\n");
    wait_idle();
    send_cmd("r3\n");
    wait_idle();
    repeat (40) begin
      int k = $urandom_range(9);
      s = "";
      if (k <= 3) begin
        s = "w";
        repeat (9) s = {s, $sformatf("%c", hexc($urandom_range(15), $urandom_range(1) == 1))};
      end else if (k <= 6) s = {"r", $sformatf("%c", hexc($urandom_range(15), $urandom_range(1) == 1))};
      else if (k == 8 || k == 9) begin
        string g = "wrxZ0aF9-";
        repeat ($urandom_range(4, 1)) s = {s, $sformatf("%c", g[$urandom_range(8)])};
      end
      if ($urandom_range(3) == 0) s = {s, "\r"};
      send_cmd({s, "\n"});
      wait_idle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  logic [7:0] s_w5[5] = '{"w", "5", "1", "2", "3"};
endmodule
